// File: rtl/param_seq_detector_if.sv
// Serial-pattern detector bus: data/control inputs towards the detector and
// the match strobe plus counter coming back.
interface param_seq_detector_if #(
    parameter int unsigned LEN   = 4,
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             i;
    logic             overlap;
    logic             pat_load;
    logic [LEN-1:0]   pat_in;
    logic             cnt_clr;
    logic             o;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    // Stream source / controller side.
    modport master (
        output en, i, overlap, pat_load, pat_in, cnt_clr,
        input  o, match_cnt, cnt_sat
    );

    // Detector side.
    modport slave (
        input  en, i, overlap, pat_load, pat_in, cnt_clr,
        output o, match_cnt, cnt_sat
    );
endinterface

// File: rtl/param_seq_detector.sv
// Parametrised Mealy serial-pattern detector with a reloadable pattern,
// selectable overlapping/non-overlapping matching, per-bit enable and a
// saturating match counter. o is a same-cycle strobe.
module param_seq_detector #(
    parameter int unsigned    LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1101,
    parameter int unsigned    CNT_W   = 8
) (
    input logic                  clk,
    input logic                  rst,
    param_seq_detector_if.slave  bus
);
    localparam int unsigned FillW = $clog2(LEN);

    logic [LEN-2:0]   hist_q, hist_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic [LEN-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             full;
    logic             match;
    logic [LEN-1:0]   window;

    // Match decode and next-state: rst > pat_load > en.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        cnt_d  = cnt_q;

        full   = (fill_q == FillW'(LEN - 1));
        // Candidate word: the LEN-1 most recent accepted bits followed by the current bit.
        window = {hist_q, bus.i};
        match  = bus.en & ~rst & ~bus.pat_load & full & (window == pat_q);

        if (bus.pat_load) begin
            pat_d  = bus.pat_in;
            fill_d = '0;
        end else if (bus.en) begin
            hist_d = window[LEN-2:0];
            if (match) begin
                // Non-overlapping mode throws away the bits consumed by this match.
                fill_d = bus.overlap ? fill_q : '0;
            end else if (!full) begin
                fill_d = fill_q + FillW'(1);
            end
        end

        if (bus.cnt_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PATTERN;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.o         = match;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = &cnt_q;
endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector: a default 1101/8-bit-counter instance
// and a 1111/2-bit-counter instance for saturation.
module tb_param_seq_detector;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    param_seq_detector_if #(.LEN(4), .CNT_W(8)) bus  ();
    param_seq_detector_if #(.LEN(4), .CNT_W(2)) bus2 ();

    param_seq_detector #(
        .LEN     (4),
        .PATTERN (4'b1101),
        .CNT_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    param_seq_detector #(
        .LEN     (4),
        .PATTERN (4'b1111),
        .CNT_W   (2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are applied 1 ns after a rising edge; o is sampled 2 ns later.
    task automatic cyc(input logic e, input logic b, output logic o_s);
        bus.en = e;
        bus.i  = b;
        #2;
        o_s = bus.o;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input logic e, input logic b, input logic clr, output logic o_s);
        bus2.en      = e;
        bus2.i       = b;
        bus2.cnt_clr = clr;
        #2;
        o_s = bus2.o;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.i        = 1'b0;
        bus.pat_load = 1'b0;
        bus.cnt_clr  = 1'b0;
        bus2.en      = 1'b0;
        bus2.i       = 1'b0;
        bus2.cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic ob;
        do_reset();
        vectors++;
        if (bus.match_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d want 0", bus.match_cnt);
        end
        vectors++;
        if (bus.cnt_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_sat: got %b want 0", bus.cnt_sat);
        end
        // First three bits can never match: history not yet full.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, ob);
            vectors++;
            if (ob !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_fill bit%0d: got %b want 0", k + 1, ob);
            end
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        logic [6:0] e;
        logic       ob;
        s = 7'b1101101;
        e = 7'b0001001;
        do_reset();
        bus.overlap = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cyc(1'b1, s[6-k], ob);
            vectors++;
            if (ob !== e[6-k]) begin
                miscompares++;
                $display("FAIL overlap bit%0d: got %b want %b", k + 1, ob, e[6-k]);
            end
        end
        vectors++;
        if (bus.match_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL overlap_cnt: got %0d want 2", bus.match_cnt);
        end
        // Clear with no match in the same cycle.
        bus.cnt_clr = 1'b1;
        cyc(1'b0, 1'bx, ob);
        bus.cnt_clr = 1'b0;
        vectors++;
        if (bus.match_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL clr_nomatch: got %0d want 0", bus.match_cnt);
        end
    endtask

    task automatic test_nonoverlap();
        logic [7:0] s;
        logic [7:0] e;
        logic       ob;
        s = 8'b11011011;
        e = 8'b00010000;
        do_reset();
        bus.overlap = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, s[7-k], ob);
            vectors++;
            if (ob !== e[7-k]) begin
                miscompares++;
                $display("FAIL nonoverlap bit%0d: got %b want %b", k + 1, ob, e[7-k]);
            end
        end
        vectors++;
        if (bus.match_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL nonoverlap_cnt: got %0d want 1", bus.match_cnt);
        end
    endtask

    task automatic test_bubbles();
        logic [6:0] en_v;
        logic [6:0] d_v;
        logic [6:0] e;
        logic       ob;
        en_v = 7'b1010101;
        d_v  = 7'b1010001;
        e    = 7'b0000001;
        do_reset();
        bus.overlap = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cyc(en_v[6-k], en_v[6-k] ? d_v[6-k] : 1'bx, ob);
            vectors++;
            if (ob !== e[6-k]) begin
                miscompares++;
                $display("FAIL bubbles step%0d: got %b want %b", k, ob, e[6-k]);
            end
        end
        vectors++;
        if (bus.match_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL bubbles_cnt: got %0d want 1", bus.match_cnt);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] s;
        logic [3:0] e;
        logic       ob;
        s = 4'b1101;
        e = 4'b0001;
        do_reset();
        bus.overlap = 1'b1;
        cyc(1'b1, 1'b1, ob);
        cyc(1'b1, 1'b1, ob);
        cyc(1'b1, 1'b0, ob);
        // A completing bit during reset must not strobe.
        rst    = 1'b1;
        bus.en = 1'b1;
        bus.i  = 1'b1;
        #2;
        vectors++;
        if (bus.o !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_o: got %b want 0", bus.o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (bus.match_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL midrst_cnt: got %0d want 0", bus.match_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, s[3-k], ob);
            vectors++;
            if (ob !== e[3-k]) begin
                miscompares++;
                $display("FAIL midrst bit%0d: got %b want %b", k + 1, ob, e[3-k]);
            end
        end
    endtask

    task automatic test_pat_load();
        logic [6:0] s;
        logic [6:0] e;
        logic       ob;
        s = 7'b0110110;
        e = 7'b0001001;
        do_reset();
        bus.overlap = 1'b1;
        cyc(1'b1, 1'b1, ob);
        cyc(1'b1, 1'b1, ob);
        cyc(1'b1, 1'b0, ob);
        // Would complete 1101, but the load takes priority and discards i.
        bus.pat_load = 1'b1;
        bus.pat_in   = 4'b0110;
        cyc(1'b1, 1'b1, ob);
        bus.pat_load = 1'b0;
        vectors++;
        if (ob !== 1'b0) begin
            miscompares++;
            $display("FAIL patload_o: got %b want 0", ob);
        end
        for (int k = 0; k < 7; k++) begin
            cyc(1'b1, s[6-k], ob);
            vectors++;
            if (ob !== e[6-k]) begin
                miscompares++;
                $display("FAIL patload bit%0d: got %b want %b", k + 1, ob, e[6-k]);
            end
        end
        vectors++;
        if (bus.match_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL patload_cnt: got %0d want 2", bus.match_cnt);
        end
    endtask

    task automatic test_cnt_sat();
        logic [6:0] e;
        logic [1:0] c;
        logic       ob;
        e = 7'b0001111;
        c = 2'd0;
        do_reset();
        bus2.overlap = 1'b1;
        bus2.pat_load = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cyc2(1'b1, 1'b1, 1'b0, ob);
            if (e[6-k] && c != 2'd3) c = c + 2'd1;
            vectors++;
            if (ob !== e[6-k]) begin
                miscompares++;
                $display("FAIL sat bit%0d: got %b want %b", k + 1, ob, e[6-k]);
            end
            vectors++;
            if (bus2.match_cnt !== c) begin
                miscompares++;
                $display("FAIL sat_cnt bit%0d: got %0d want %0d", k + 1, bus2.match_cnt, c);
            end
        end
        vectors++;
        if (bus2.cnt_sat !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_flag: got %b want 1", bus2.cnt_sat);
        end
        // Clear together with a match counts that match.
        cyc2(1'b1, 1'b1, 1'b1, ob);
        vectors++;
        if (ob !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_match_o: got %b want 1", ob);
        end
        vectors++;
        if (bus2.match_cnt !== 2'd1) begin
            miscompares++;
            $display("FAIL clr_match_cnt: got %0d want 1", bus2.match_cnt);
        end
        vectors++;
        if (bus2.cnt_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_match_sat: got %b want 0", bus2.cnt_sat);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.i         = 1'b0;
        bus.overlap   = 1'b1;
        bus.pat_load  = 1'b0;
        bus.pat_in    = '0;
        bus.cnt_clr   = 1'b0;
        bus2.en       = 1'b0;
        bus2.i        = 1'b0;
        bus2.overlap  = 1'b1;
        bus2.pat_load = 1'b0;
        bus2.pat_in   = '0;
        bus2.cnt_clr  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_bubbles();
        test_mid_reset();
        test_pat_load();
        test_cnt_sat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
